// File: rtl/time_keeper.sv
// Time-of-day counter: edge-detects the 1 Hz divider output and advances a BCD
// hh:mm:ss count in 24-hour or 12-hour (AM/PM) form, with manual field setting.
module time_keeper #(
   parameter logic HOUR_MODE_12 = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sec,
   input  logic       set_mode,
   input  logic [1:0] set_sel,
   input  logic       inc,
   output logic [3:0] hr_t,
   output logic [3:0] hr_o,
   output logic [3:0] mn_t,
   output logic [3:0] mn_o,
   output logic [3:0] sc_t,
   output logic [3:0] sc_o,
   output logic       pm,
   output logic       tick
);

   localparam logic [7:0] HR_RST = HOUR_MODE_12 ? 8'h12 : 8'h00;

   logic       sec_d_r;
   logic       tick_r;
   logic       pm_r;
   logic [7:0] hr_r;
   logic [7:0] mn_r;
   logic [7:0] sc_r;

   logic       tick_i_s;
   logic       adv_s;
   logic [7:0] hr_step_s;
   logic       pm_step_s;
   logic [7:0] hr_s;
   logic [7:0] mn_s;
   logic [7:0] sc_s;
   logic       pm_s;

   // Two-digit BCD increment; callers handle the field limit.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   assign tick_i_s = sec & ~sec_d_r;
   assign adv_s    = tick_i_s & ~set_mode;

   // Next hour value under the selected mode's wrap rule.
   always_comb begin
      hr_step_s = bcd_inc(hr_r);
      pm_step_s = pm_r;
      if (HOUR_MODE_12) begin
         if (hr_r == 8'h12) begin
            hr_step_s = 8'h01;
         end else if (hr_r == 8'h11) begin
            hr_step_s = 8'h12;
            pm_step_s = ~pm_r;
         end else begin
            hr_step_s = bcd_inc(hr_r);
         end
      end else begin
         if (hr_r == 8'h23) begin
            hr_step_s = 8'h00;
         end else begin
            hr_step_s = bcd_inc(hr_r);
         end
      end
   end

   // Next count: full carry chain on a run tick, single-field edit on inc.
   always_comb begin
      sc_s = sc_r;
      mn_s = mn_r;
      hr_s = hr_r;
      pm_s = pm_r;
      if (adv_s) begin
         if (sc_r == 8'h59) begin
            sc_s = 8'h00;
            if (mn_r == 8'h59) begin
               mn_s = 8'h00;
               hr_s = hr_step_s;
               pm_s = pm_step_s;
            end else begin
               mn_s = bcd_inc(mn_r);
            end
         end else begin
            sc_s = bcd_inc(sc_r);
         end
      end else if (set_mode && inc) begin
         case (set_sel)
            2'd0: sc_s = 8'h00;
            2'd1: mn_s = (mn_r == 8'h59) ? 8'h00 : bcd_inc(mn_r);
            2'd2: begin
               hr_s = hr_step_s;
               pm_s = pm_step_s;
            end
            default: sc_s = sc_r;
         endcase
      end else begin
         sc_s = sc_r;
      end
   end

   // State registers; sec_d resets high so a high sec at reset release is not an edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sec_d_r <= 1'b1;
         tick_r  <= 1'b0;
         pm_r    <= 1'b0;
         hr_r    <= HR_RST;
         mn_r    <= 8'h00;
         sc_r    <= 8'h00;
      end else begin
         sec_d_r <= sec;
         tick_r  <= adv_s;
         pm_r    <= pm_s;
         hr_r    <= hr_s;
         mn_r    <= mn_s;
         sc_r    <= sc_s;
      end
   end

   assign hr_t = hr_r[7:4];
   assign hr_o = hr_r[3:0];
   assign mn_t = mn_r[7:4];
   assign mn_o = mn_r[3:0];
   assign sc_t = sc_r[7:4];
   assign sc_o = sc_r[3:0];
   assign pm   = pm_r;
   assign tick = tick_r;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: one 24-hour and one 12-hour instance share stimulus and
// are checked every cycle against a seconds-of-day reference model.
module tb_time_keeper;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sec = 1'b1;
   logic       set_mode = 1'b0;
   logic [1:0] set_sel = 2'd3;
   logic       inc = 1'b0;

   logic [3:0] a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o;
   logic [3:0] b_hr_t, b_hr_o, b_mn_t, b_mn_o, b_sc_t, b_sc_o;
   logic       a_pm, a_tick, b_pm, b_tick;
   logic [31:0] obs24, obs12;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: plain 24-hour time of day plus edge history
   int  h = 0, m = 0, s = 0;
   bit  prev_sec = 1'b1;
   bit  exp_tick = 1'b0;

   always #5 clk = ~clk;

   time_keeper #(.HOUR_MODE_12(1'b0)) dut24 (
      .clk(clk), .rst(rst), .sec(sec), .set_mode(set_mode), .set_sel(set_sel), .inc(inc),
      .hr_t(a_hr_t), .hr_o(a_hr_o), .mn_t(a_mn_t), .mn_o(a_mn_o), .sc_t(a_sc_t), .sc_o(a_sc_o),
      .pm(a_pm), .tick(a_tick));

   time_keeper #(.HOUR_MODE_12(1'b1)) dut12 (
      .clk(clk), .rst(rst), .sec(sec), .set_mode(set_mode), .set_sel(set_sel), .inc(inc),
      .hr_t(b_hr_t), .hr_o(b_hr_o), .mn_t(b_mn_t), .mn_o(b_mn_o), .sc_t(b_sc_t), .sc_o(b_sc_o),
      .pm(b_pm), .tick(b_tick));

   assign obs24 = {6'd0, a_tick, a_pm, a_hr_t, a_hr_o, a_mn_t, a_mn_o, a_sc_t, a_sc_o};
   assign obs12 = {6'd0, b_tick, b_pm, b_hr_t, b_hr_o, b_mn_t, b_mn_o, b_sc_t, b_sc_o};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   // expected {tick, pm, hh, mm, ss} as shown by a 24- or 12-hour display
   function automatic logic [31:0] exp_disp(input bit m12);
      int   hd;
      logic p;
      if (m12) begin
         hd = (h % 12 == 0) ? 12 : h % 12;
         p  = (h >= 12);
      end else begin
         hd = h;
         p  = 1'b0;
      end
      return {6'd0, exp_tick, p, to_bcd(hd), to_bcd(m), to_bcd(s)};
   endfunction

   // apply current inputs for one clock, advance the model, then check both displays
   task automatic step();
      exp_tick = 1'b0;
      if (!rst) begin
         h = 0; m = 0; s = 0;
         prev_sec = 1'b1;
      end else begin
         if (sec && !prev_sec && !set_mode) begin
            exp_tick = 1'b1;
            s = s + 1;
            if (s == 60) begin
               s = 0;
               m = m + 1;
               if (m == 60) begin
                  m = 0;
                  h = (h + 1) % 24;
               end
            end
         end else if (set_mode && inc) begin
            case (set_sel)
               2'd0: s = 0;
               2'd1: m = (m + 1) % 60;
               2'd2: h = (h + 1) % 24;
               default: ;
            endcase
         end
         prev_sec = sec;
      end
      @(posedge clk);
      #1;
      check_val("disp24", obs24, exp_disp(1'b0));
      check_val("disp12", obs12, exp_disp(1'b1));
   endtask

   task automatic sec_edge();
      sec = 1'b0;
      step();
      sec = 1'b1;
      step();
   endtask

   task automatic pulse_inc();
      inc = 1'b1;
      step();
      inc = 1'b0;
      step();
   endtask

   // reach a target time: hours and minutes via setting, seconds via run ticks
   task automatic goto(input int th, input int tm, input int ts);
      set_mode = 1'b1;
      set_sel  = 2'd2;
      while (h != th) pulse_inc();
      set_sel = 2'd1;
      while (m != tm) pulse_inc();
      set_sel = 2'd0;
      pulse_inc();
      set_sel  = 2'd3;
      set_mode = 1'b0;
      while (s != ts) sec_edge();
   endtask

   initial begin
      // reset held with sec high; release must not produce a tick
      rst = 1'b0; sec = 1'b1;
      repeat (3) step();
      rst = 1'b1;
      repeat (3) step();
      sec_edge();
      step();

      // run increment 58 -> 59 -> 1:00
      goto(0, 0, 58);
      sec_edge(); step();
      sec_edge(); step(); step();

      // full wrap in 24-hour view (11:59:59 PM -> 12:00:00 AM in 12-hour view)
      goto(23, 59, 59);
      sec_edge(); step();

      // 12-hour boundaries
      goto(11, 59, 59);
      sec_edge(); step();
      goto(12, 59, 59);
      sec_edge(); step();

      // setting minutes with sec edges interleaved, back-to-back inc, then clear seconds
      goto(4, 58, 7);
      set_mode = 1'b1; set_sel = 2'd1;
      pulse_inc();
      sec_edge();
      inc = 1'b1; step(); step(); inc = 1'b0; step();
      sec_edge();
      set_sel = 2'd0; pulse_inc();
      set_sel = 2'd3; pulse_inc();
      set_mode = 1'b0; step();

      // sec edge coinciding with set_mode rising is discarded
      sec = 1'b0; step();
      sec = 1'b1; set_mode = 1'b1; step();
      step();
      set_mode = 1'b0; step();

      // reset coinciding with a tick
      goto(5, 7, 3);
      sec = 1'b0; step();
      sec = 1'b1; rst = 1'b0; step();
      rst = 1'b1; step(); step();

      // randomized traffic near a carry boundary
      goto(23, 59, 50);
      for (int i = 0; i < 600; i++) begin
         sec      = 1'($urandom_range(0, 1));
         set_mode = ($urandom_range(0, 3) == 0);
         set_sel  = 2'($urandom_range(0, 3));
         inc      = 1'($urandom_range(0, 1));
         rst      = ($urandom_range(0, 99) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day counter that sits directly downstream of the 50 MHz-to-1 Hz divider. It edge-detects the divider's 1 Hz square wave and advances a BCD seconds/minutes/hours count. It supports manual time setting and drives six BCD digits to the seven-segment display stage.

## Interface
- HOUR_MODE_12, default 0: 0 selects 24-hour count (00–23); 1 selects 12-hour count (01–12) with the `pm` flag.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset; synchronous, active-low (asserted when 0, sampled on rising `clk`).
- sec  input  1  1 Hz square wave from the divider, synchronous to `clk`; resets high upstream.
- set_mode  input  1  1 = setting mode: `sec` ticks are ignored and `inc` is honoured.
- set_sel  input  2  field select in setting mode: 0 = seconds, 1 = minutes, 2 = hours, 3 = none.
- inc  input  1  single-cycle, already-debounced increment request.
- hr_t, hr_o  output  4 each  hours tens/ones, BCD.
- mn_t, mn_o  output  4 each  minutes tens/ones, BCD.
- sc_t, sc_o  output  4 each  seconds tens/ones, BCD.
- pm  output  1  PM flag; always 0 when HOUR_MODE_12 = 0.
- tick  output  1  one-cycle registered pulse, high the cycle after the count advances from `sec`.

## Operation
- **Edge detect:** `sec_d` registers `sec`. `tick_i` = `sec & ~sec_d`.
- **Reset value of `sec_d`:** 1, so no spurious tick occurs on the upstream reset release.
- **Run mode (`set_mode` = 0):**
  - Each `tick_i` increments seconds.
  - Seconds 59 → 00 carries to minutes.
  - Minutes 59 → 00 carries to hours.
  - 24-hour wrap: 23:59:59 → 00:00:00.
  - 12-hour wrap: 11:59:59 → 12:00:00 with `pm` toggled; 12:59:59 → 01:00:00 with `pm` unchanged.
  - `inc` is ignored.
- **Setting mode (`set_mode` = 1):**
  - `tick_i` is ignored; the count is frozen and `tick` stays low.
  - `inc` with `set_sel` = 0: seconds cleared to 00.
  - `inc` with `set_sel` = 1: minutes +1, 59 → 00, no carry into hours.
  - `inc` with `set_sel` = 2: hours +1 using the mode's wrap rule (23 → 00; or 12 → 01 and 11 → 12 with `pm` toggle), no carry.
  - `inc` with `set_sel` = 3: no effect.
- **Digit arithmetic:**
  - Each field is kept as two BCD digits.
  - Ones digit wraps 9 → 0 and increments tens.
  - Field limits are compared on the full two-digit value.
  - Ones digit never exceeds 9; tens never exceeds 5 (min/sec) or 2/1 (hours, per mode).
- **Leaving setting mode:** counting resumes from the set value on the next `tick_i`. Seconds never jump to catch up on missed ticks.
- **Reset values (`rst` = 0):**
  - All digits 0, except `hr_t`/`hr_o` = 1/2 in 12-hour mode (12:00:00 AM).
  - `pm` = 0, `tick` = 0, `sec_d` = 1.
  - Reset overrides every other input in the same cycle, including mid-set and mid-carry.

## Timing
- **Latency:** `sec` sampled high with `sec_d` = 0 in cycle N. Digits show the new value and `tick` = 1 in cycle N+1. `tick` is low again in N+2.
- **Carry:** a full carry chain (e.g. 23:59:59 → 00:00:00) completes in the same single cycle. No intermediate values are ever visible.
- **Ticks per second:** at most one `tick_i`, since the rising edge of `sec` occurs once per second.
- **`set_mode` toggling in the same cycle as `tick_i`:** the value of `set_mode` in that cycle decides. 1 means the tick is discarded; 0 means the tick is counted.
- **`inc` in setting mode:** takes effect one cycle after it is sampled. Back-to-back `inc` pulses each apply.
- All outputs are registered and glitch-free.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles with `sec` = 1, then release → 24-hour outputs 00:00:00, `pm` = 0, `tick` = 0, and no tick until `sec` falls and rises again.
- **Run increment:** preset 00:00:58, apply 2 `sec` rising edges → 00:00:59 then 00:01:00, each change exactly 1 cycle after `sec` is sampled high, `tick` one cycle wide.
- **Full wrap, 24-hour:** preset 23:59:59, one rising edge → 00:00:00 in one cycle.
- **Full wrap, 12-hour:** 11:59:59 AM → 12:00:00 with `pm` = 1; 12:59:59 → 01:00:00 with `pm` unchanged.
- **Setting:** `set_mode` = 1, `set_sel` = 1, 3 `inc` pulses from minutes 58 → 59, 00, 01 with hours unchanged; `sec` edges during setting cause no change; `set_sel` = 0 with `inc` → seconds 00.
- **Simultaneous events:**
  - `sec` edge in the same cycle as `set_mode` rising → tick discarded.
  - `rst` = 0 in the same cycle as `tick_i` → reset values win.
